// File: rtl/seq_tx_if.sv
// Bundles the frame request inputs and the serial/status outputs of seq_tx.
// The master side requests frames, the slave side (the transmitter) serves them.
interface seq_tx_if #(
    parameter int WIDTH = 8
) ();
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    len;
    logic             q;
    logic             busy;
    logic             done;

    modport master (
        output start, data, len,
        input  q, busy, done
    );

    modport slave (
        input  start, data, len,
        output q, busy, done
    );
endinterface

// File: rtl/seq_tx.sv
// Serial frame transmitter: shifts out up to WIDTH bits LSB first, then holds
// the line low for GAP forced-idle cycles, then pulses done for one cycle.
// All outputs come straight from registers, so nothing from the request side
// reaches q, busy or done combinationally.
module seq_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic     clk,
    input  logic     reset,
    seq_tx_if.slave  bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int CW = (LW > GW) ? LW : GW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_q;
    logic             r_busy;
    logic             r_done;

    logic [LW-1:0]    w_lenClamped;
    logic             w_accept;

    // Requests longer than the shift register are cut to WIDTH bits; a zero
    // length request is not a frame at all.
    assign w_lenClamped = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
    assign w_accept     = bus.start && (bus.len != '0);

    // Frame sequencer: r_cnt holds the bits still to send after the one on q,
    // and in S_GAP the idle cycles still to spend after the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_q    <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        r_q     <= bus.data[0];
                        r_shift <= {1'b0, bus.data[WIDTH-1:1]};
                        r_cnt   <= CW'(w_lenClamped - LW'(1));
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_done <= 1'b0;
                    if (r_cnt == '0) begin
                        r_q <= 1'b0;
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_cnt   <= CW'(GAP - 1);
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_q     <= r_shift[0];
                        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    r_q    <= 1'b0;
                    r_done <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_q     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx (WIDTH=8, GAP=2). Every expected value is written
// out by hand as {q, busy, done} for the cycle after each rising edge.
module tb_seq_tx;
    logic clk;
    logic reset;

    int checks;
    int errors;

    seq_tx_if #(.WIDTH(8)) bus ();

    seq_tx #(.WIDTH(8), .GAP(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge detector fed by the serial line, as used in loopback.
    logic qPrev;
    logic detPulse;
    int   detCount;

    assign detPulse = bus.q & ~qPrev;

    // Remembers the previous serial bit for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) qPrev <= 1'b0;
        else        qPrev <= bus.q;
    end

    // Counts detector pulses over the whole run.
    always_ff @(posedge clk) begin
        if (reset && detPulse) detCount <= detCount + 1;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic s, input logic [7:0] d, input logic [3:0] l);
        bus.start = s;
        bus.data  = d;
        bus.len   = l;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] expQbd);
        logic [2:0] obs;
        obs = {bus.q, bus.busy, bus.done};
        checks++;
        assert (obs === expQbd) else begin
            errors++;
            $error("[TB] FAIL %s: observed qbd=%b required qbd=%b", tag, obs, expQbd);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int expVal);
        checks++;
        assert (obs === expVal) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, expVal);
        end
    endtask

    logic [2:0] expF1   [8];
    logic [2:0] expB2B  [12];
    logic [2:0] expIgn  [9];
    logic [2:0] expClmp [12];
    logic [2:0] expLoop [7];
    int         detBefore;

    initial begin
        checks   = 0;
        errors   = 0;
        detCount = 0;

        // data=0110 len=4: bits 0,1,1,0, two gap cycles, done, idle
        expF1   = '{3'b010, 3'b110, 3'b110, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        // 0xFF len=3 twice, start held: 1,1,1, gap, gap, done, repeat
        expB2B  = '{3'b110, 3'b110, 3'b110, 3'b010, 3'b010, 3'b001,
                    3'b110, 3'b110, 3'b110, 3'b010, 3'b010, 3'b001};
        // 0x0D len=5: bits 1,0,1,1,0, gap, gap, done, idle
        expIgn  = '{3'b110, 3'b010, 3'b110, 3'b110, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        // 0xA5 len=15 clamps to 8: bits 1,0,1,0,0,1,0,1, gap, gap, done, idle
        expClmp = '{3'b110, 3'b010, 3'b110, 3'b010, 3'b010, 3'b110, 3'b010, 3'b110,
                    3'b010, 3'b010, 3'b001, 3'b000};
        // 0x02 len=3: bits 0,1,0, gap, gap, done, idle
        expLoop = '{3'b010, 3'b110, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};

        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 4'd0);
        nextCycle();
        nextCycle();
        checkOutput("reset state", 3'b000);
        reset = 1'b1;
        nextCycle();
        checkOutput("idle after reset", 3'b000);

        // Single frame
        applyStimulus(1'b1, 8'b0000_0110, 4'd4);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("single cyc%0d", i), expF1[i]);
            nextCycle();
        end

        // Back-to-back frames with start held high
        applyStimulus(1'b1, 8'hFF, 4'd3);
        nextCycle();
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("b2b cyc%0d", i), expB2B[i]);
            if (i == 11) applyStimulus(1'b0, 8'h00, 4'd0);
            nextCycle();
        end
        checkOutput("b2b idle", 3'b000);

        // Zero-length request is ignored
        applyStimulus(1'b1, 8'hFF, 4'd0);
        nextCycle();
        checkOutput("len0 cyc0", 3'b000);
        nextCycle();
        checkOutput("len0 cyc1", 3'b000);

        // Start pulses and input changes during SHIFT have no effect
        applyStimulus(1'b1, 8'h0D, 4'd5);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("ignore cyc%0d", i), expIgn[i]);
            if (i == 1) applyStimulus(1'b1, 8'h00, 4'd2);
            if (i == 3) applyStimulus(1'b0, 8'hF0, 4'd7);
            nextCycle();
        end

        // Length clamping
        applyStimulus(1'b1, 8'hA5, 4'd15);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("clamp cyc%0d", i), expClmp[i]);
            nextCycle();
        end

        // Reset asserted during bit 2 aborts the frame without done
        applyStimulus(1'b1, 8'hFF, 4'd6);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        checkOutput("abort bit0", 3'b110);
        nextCycle();
        checkOutput("abort bit1", 3'b110);
        nextCycle();
        checkOutput("abort bit2", 3'b110);
        #2 reset = 1'b0;
        #1 checkOutput("abort immediate", 3'b000);
        nextCycle();
        checkOutput("abort held", 3'b000);
        nextCycle();
        checkOutput("abort no done", 3'b000);
        reset = 1'b1;
        applyStimulus(1'b1, 8'b0000_0110, 4'd4);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("post-reset cyc%0d", i), expF1[i]);
            nextCycle();
        end

        // Loopback into the rising-edge detector
        detBefore = detCount;
        applyStimulus(1'b1, 8'b0000_0010, 4'd3);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("loop cyc%0d", i), expLoop[i]);
            nextCycle();
        end
        checkCount("loop detector pulses", detCount - detBefore, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the maximum frame length in bits (2..16).
REQ-002 SHALL have parameter GAP, default 2, the number of forced-idle cycles after each frame (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; low clears all state immediately, independent of clk.
REQ-005 SHALL have port start, input, 1, frame request, sampled on the rising clk edge.
REQ-006 SHALL have port data, input, WIDTH, the frame bits, sent LSB first.
REQ-007 SHALL have port len, input, $clog2(WIDTH+1), the number of bits to send.
REQ-008 SHALL have port q, output, 1, the serial bit stream (same stream format the team's sequence detectors consume).
REQ-009 SHALL have port busy, output, 1, high while a frame or its gap is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement the states IDLE, SHIFT and GAP.
REQ-012 SHALL drive q, busy and done directly from registers, with no combinational path from any input.
REQ-013 SHALL accept a frame only in IDLE, on an edge where start=1 and len!=0; on that edge it SHALL capture data and len internally.
REQ-014 SHALL treat len>WIDTH as WIDTH.
REQ-015 SHALL ignore start=1 with len=0: state stays IDLE, no busy, no done.
REQ-016 SHALL, when a frame is accepted at edge T, go to SHIFT with q=data[0] and busy=1 in the cycle after T.
REQ-017 SHALL drive q=data[n] during the cycle after edge T+n, for n=0..len-1.
REQ-018 SHALL ignore start, data and len changes while busy=1; captured values alone define the frame.
REQ-019 SHALL, after the last bit, spend exactly GAP cycles in GAP with q=0 and busy=1; GAP=0 skips the GAP state.
REQ-020 SHALL, after GAP completes, return to IDLE with busy=0, q=0 and done=1 for exactly one cycle.
REQ-021 SHALL accept start in the done cycle, so frames can run back to back with no extra idle cycle.
REQ-022 SHALL hold q=0 in IDLE at all times.
REQ-023 SHALL keep the bit counter wide enough for WIDTH and GAP, with no wrap-around.
REQ-024 SHALL recover any illegal state encoding to IDLE on the next edge.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, q=0, busy=0, done=0 and clear the bit/gap counters.
REQ-026 SHALL, on reset assertion mid-frame (SHIFT or GAP), abort the frame immediately with no done pulse.
REQ-027 SHALL, after reset deasserts, accept start on the next rising edge.

Verification
REQ-028 SHALL verify a single frame: WIDTH=8, GAP=2, data=8'b0000_0110, len=4, start pulse at edge T -> q=0,1,1,0 over cycles T+1..T+4; q=0 with busy=1 for 2 cycles; then done=1 for one cycle, busy=0.
REQ-029 SHALL verify back-to-back frames: start held high with data=8'hFF, len=3 -> q=1,1,1,0,0 then done; the next frame's first bit follows the done cycle directly; busy drops only during done cycles.
REQ-030 SHALL verify ignored requests: start with len=0 -> busy stays 0, no done; start pulses during SHIFT -> no effect on q or timing.
REQ-031 SHALL verify clamping: len=15, data=8'hA5 -> exactly 8 bits 1,0,1,0,0,1,0,1, then gap, then done.
REQ-032 SHALL verify reset mid-frame: reset=0 asserted during bit 2 -> q=0, busy=0 immediately and no done; after release, a new frame works normally.
REQ-033 SHALL verify loopback: q drives the team's rising-edge sequence detector with data=8'b0000_0010, len=3 -> detector output pulses exactly once.
